qspi_flash_seq: RTL and testbench
=================================

// Module: qspi_flash_seq
// PURPOSE
//  Command sequencer directly upstream of the QSPI driver: drives its cmd_type/cmd_code/addr request bus,
//  consumes done/read-byte strobes, and runs one self-test: read ID, WREN, sector erase, WIP poll,
//  WREN, 256-byte page program, WIP poll, 256-byte read and compare. Results feed top-level LEDs/ILA.
// PARAMETERS
//  FLASH_ADDR  24'h000000  base address for erase/program/read (page aligned, low byte must be 0)
//  POLL_GAP    16'd250     idle cycles between consecutive status reads
//  POLL_MAX    20'd400000  max status reads per poll phase before timeout
//  PAT_SEED    8'h00       expected byte i = PAT_SEED + i (mod 256); program ROM init holds the same pattern
// PORTS
//  I_clk_25M        in   1   25 MHz clock (same clock as driver; this block uses posedge only)
//  I_rst            in   1   asynchronous, active-high reset (driver reset tied to ~I_rst at top)
//  I_start          in   1   1-cycle pulse; starts the test when idle, ignored while busy
//  O_cmd_type       out  5   [4]=request, [3:0] type: 0000 RDID,0001 WREN,0010 SE,0011 RDSR,0101 PP,0111 READ
//  O_cmd_code       out  8   opcode: 90/06/20/05/02/03 (hex) matching type
//  O_qspi_addr      out  24  FLASH_ADDR for RDID(=0)/SE/PP/READ, 0 otherwise
//  I_done_sig       in   1   driver command-complete, high one clock
//  I_read_data      in   8   driver read byte
//  I_read_byte_valid in  1   driver byte strobe, 1 cycle
//  O_busy           out  1   test running
//  O_pass           out  1   test finished, 0 mismatches, no timeout (sticky until next start)
//  O_fail           out  1   test finished with mismatch or timeout (sticky until next start)
//  O_timeout        out  1   a WIP poll exceeded POLL_MAX (sticky until next start)
//  O_dev_id         out  16  {mfr, dev} captured from RDID
//  O_err_cnt        out  9   mismatching bytes in readback (0..256)
//  O_seq_state      out  4   current state encoding, debug
// BEHAVIOUR
//  Reset: all outputs 0, state S_IDLE, request low; reset mid-run aborts immediately, no flags set.
//  States (4'h0..4'hB): S_IDLE,S_RDID,S_WREN1,S_SE,S_POLL1,S_WREN2,S_PP,S_POLL2,S_READ,S_DONE,S_GAP,S_TOUT.
//  I_start in S_IDLE: clear pass/fail/timeout/err_cnt/dev_id, busy<=1, go S_RDID.
//  Command handshake (every command state): on entry set type/code/addr, then O_cmd_type[4]<=1 next
//   cycle; hold all three stable while request high; on posedge with I_done_sig=1 drop request same edge
//   and advance. New request never asserted sooner than 2 cycles after request dropped (driver IDLE gap).
//  Spurious I_done_sig with request low: ignored. I_read_byte_valid outside RDID/RDSR/READ: ignored.
//  RDID: byte0 -> dev_id[15:8], byte1 -> dev_id[7:0].
//  POLL: issue RDSR, latch status byte; on done: bit0(WIP)=0 -> next state; else poll_cnt+1, wait POLL_GAP
//   cycles in S_GAP, reissue. poll_cnt reset on entering each poll phase; poll_cnt==POLL_MAX -> S_TOUT.
//  READ: byte index idx 0..255 (8 bit, wraps to 0 after 255); compare I_read_data vs PAT_SEED+idx,
//   err_cnt+1 per mismatch, saturates at 256 (9 bit). Valid strobe coincident with done: byte still counted.
//  S_DONE: busy<=0; pass<=(err_cnt==0), fail<=~pass (pass and fail never both 1), -> S_IDLE.
//  S_TOUT: timeout<=1, fail<=1, busy<=0 -> S_IDLE. I_start during busy: no effect.
// STRUCTURE
//  Package qspi_pkg: cmd type enum (4 bit), opcode constants, seq state enum, WIP bit index.
//  Sub-module qspi_cmd_issue: one-command handshake FSM (req/hold/wait-done/gap), reused by every state.
// TESTING (bench drives a behavioural driver model honouring the same handshake, or real driver + flash model)
//  1 start, model returns ID EF,16, WIP clear, pattern 00..FF -> dev_id=16'hEF16, pass=1, err_cnt=0, busy 1->0.
//  2 readback byte 0x37 corrupted to 0x00 -> err_cnt=1, fail=1, pass=0.
//  3 status returns 0x01 for 5 reads then 0x00 in POLL1 -> exactly 6 RDSR requests, gaps >=POLL_GAP cycles.
//  4 POLL_MAX=4, status stuck 0x03 -> timeout=1, fail=1, no PP request ever issued.
//  5 assert I_rst during S_PP -> request low next cycle, outputs 0; new start runs full sequence cleanly.
//  6 I_start pulsed while busy and extra done pulses while request low -> sequence order/count unchanged.

Source files
------------

// File: rtl/qspi_flash_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : qspi_flash_seq_pkg
// Brief   : Shared command types, opcodes and sequencer state encodings for
//           the QSPI flash self-test sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package qspi_flash_seq_pkg;

  // Command type field driven to the QSPI driver (low nibble of cmd_type)
  typedef enum logic [3:0] {
    CMD_RDID = 4'h0,
    CMD_WREN = 4'h1,
    CMD_SE   = 4'h2,
    CMD_RDSR = 4'h3,
    CMD_PP   = 4'h5,
    CMD_READ = 4'h7
  } cmd_type_e;

  localparam logic [7:0] OP_RDID = 8'h90;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_SE   = 8'h20;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_READ = 8'h03;

  // Write-in-progress flag position in the flash status register
  localparam int WIP_BIT = 0;

  // Sequencer states, also exported on seq_state for debug
  localparam logic [3:0] S_IDLE  = 4'h0;
  localparam logic [3:0] S_RDID  = 4'h1;
  localparam logic [3:0] S_WREN1 = 4'h2;
  localparam logic [3:0] S_SE    = 4'h3;
  localparam logic [3:0] S_POLL1 = 4'h4;
  localparam logic [3:0] S_WREN2 = 4'h5;
  localparam logic [3:0] S_PP    = 4'h6;
  localparam logic [3:0] S_POLL2 = 4'h7;
  localparam logic [3:0] S_READ  = 4'h8;
  localparam logic [3:0] S_DONE  = 4'h9;
  localparam logic [3:0] S_GAP   = 4'hA;
  localparam logic [3:0] S_TOUT  = 4'hB;

  // Opcode that belongs to a command type
  function automatic logic [7:0] opcode_of(input logic [3:0] t);
    logic [7:0] op;
    op = 8'h00;
    case (t)
      CMD_RDID: op = OP_RDID;
      CMD_WREN: op = OP_WREN;
      CMD_SE:   op = OP_SE;
      CMD_RDSR: op = OP_RDSR;
      CMD_PP:   op = OP_PP;
      CMD_READ: op = OP_READ;
      default:  op = 8'h00;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/qspi_flash_seq_cmd_issue.sv
`default_nettype none
// ============================================================================
// Module  : qspi_flash_seq_cmd_issue
// Brief   : One-command handshake toward the QSPI driver. Latches the
//           command fields, raises the request a cycle later, holds the bus
//           stable until done, then enforces an idle gap before the next go.
// Revision: 1.0 - initial release
// ============================================================================
module qspi_flash_seq_cmd_issue
  import qspi_flash_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [3:0]  go_type,
  input  logic [23:0] go_addr,
  input  logic        done_sig,
  output logic        idle,
  output logic        cmd_done,
  output logic [4:0]  cmd_type,
  output logic [7:0]  cmd_code,
  output logic [23:0] qspi_addr
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_REQ  = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  logic [1:0]  r_state;
  logic        r_req;
  logic [3:0]  r_type;
  logic [7:0]  r_code;
  logic [23:0] r_addr;

  assign idle      = (r_state == ST_IDLE);
  // done only counts while our request is actually outstanding
  assign cmd_done  = (r_state == ST_REQ) && done_sig;
  assign cmd_type  = {r_req, r_type};
  assign cmd_code  = r_code;
  assign qspi_addr = r_addr;

  // Handshake FSM: fields first, request next cycle, drop on done, one gap cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_type  <= 4'h0;
      r_code  <= 8'h00;
      r_addr  <= 24'h000000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (go) begin
            r_type  <= go_type;
            r_code  <= opcode_of(go_type);
            r_addr  <= go_addr;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_req   <= 1'b1;
          r_state <= ST_REQ;
        end
        ST_REQ: begin
          if (done_sig) begin
            r_req   <= 1'b0;
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/qspi_flash_seq.sv
`default_nettype none
// ============================================================================
// Module  : qspi_flash_seq
// Brief   : QSPI flash self-test sequencer: RDID, WREN, sector erase, WIP
//           poll, WREN, page program, WIP poll, 256-byte read and compare.
// Revision: 1.0 - initial release
// ============================================================================
module qspi_flash_seq
  import qspi_flash_seq_pkg::*;
#(
  parameter logic [23:0] FLASH_ADDR = 24'h000000,
  parameter logic [15:0] POLL_GAP   = 16'd250,
  parameter logic [19:0] POLL_MAX   = 20'd400000,
  parameter logic [7:0]  PAT_SEED   = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  cmd_type,
  output logic [7:0]  cmd_code,
  output logic [23:0] qspi_addr,
  input  logic        done_sig,
  input  logic [7:0]  read_data,
  input  logic        read_byte_valid,
  output logic        busy,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [15:0] dev_id,
  output logic [8:0]  err_cnt,
  output logic [3:0]  seq_state
);

  logic [3:0]  r_state;
  logic [3:0]  r_ret;
  logic        r_busy;
  logic        r_pass;
  logic        r_fail;
  logic        r_timeout;
  logic [15:0] r_dev_id;
  logic [8:0]  r_err_cnt;
  logic [7:0]  r_idx;
  logic        r_wip;
  logic [19:0] r_poll_cnt;
  logic [15:0] r_gap_cnt;

  logic        w_cmd_state;
  logic [3:0]  w_go_type;
  logic [23:0] w_go_addr;
  logic        w_go;
  logic        w_issue_idle;
  logic        w_cmd_done;
  logic        w_rx;
  logic        w_poll;
  logic        w_wip;

  qspi_flash_seq_cmd_issue u_issue (
    .clk       (clk),
    .rst       (rst),
    .go        (w_go),
    .go_type   (w_go_type),
    .go_addr   (w_go_addr),
    .done_sig  (done_sig),
    .idle      (w_issue_idle),
    .cmd_done  (w_cmd_done),
    .cmd_type  (cmd_type),
    .cmd_code  (cmd_code),
    .qspi_addr (qspi_addr)
  );

  // Command fields requested by the current sequencer state
  always_comb begin
    w_cmd_state = 1'b1;
    w_go_type   = CMD_RDID;
    w_go_addr   = 24'h000000;
    case (r_state)
      S_RDID:           w_go_type = CMD_RDID;
      S_WREN1, S_WREN2: w_go_type = CMD_WREN;
      S_SE: begin
        w_go_type = CMD_SE;
        w_go_addr = FLASH_ADDR;
      end
      S_POLL1, S_POLL2: w_go_type = CMD_RDSR;
      S_PP: begin
        w_go_type = CMD_PP;
        w_go_addr = FLASH_ADDR;
      end
      S_READ: begin
        w_go_type = CMD_READ;
        w_go_addr = FLASH_ADDR;
      end
      default:          w_cmd_state = 1'b0;
    endcase
  end

  assign w_go   = w_cmd_state && w_issue_idle;
  // bytes are only accepted while our request is outstanding
  assign w_rx   = read_byte_valid && cmd_type[4];
  assign w_poll = (r_state == S_POLL1) || (r_state == S_POLL2);
  // a status byte arriving together with done must still decide the poll
  assign w_wip  = (w_rx && w_poll) ? read_data[WIP_BIT] : r_wip;

  assign busy      = r_busy;
  assign pass      = r_pass;
  assign fail      = r_fail;
  assign timeout   = r_timeout;
  assign dev_id    = r_dev_id;
  assign err_cnt   = r_err_cnt;
  assign seq_state = r_state;

  // Byte capture plus the test-sequence state machine
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ret      <= S_POLL1;
      r_busy     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
      r_timeout  <= 1'b0;
      r_dev_id   <= 16'h0000;
      r_err_cnt  <= 9'd0;
      r_idx      <= 8'd0;
      r_wip      <= 1'b0;
      r_poll_cnt <= 20'd0;
      r_gap_cnt  <= 16'd0;
    end else begin
      if (w_go) begin
        r_idx <= 8'd0;
      end else if (w_rx && ((r_state == S_RDID) || (r_state == S_READ))) begin
        r_idx <= r_idx + 8'd1;
      end

      if (w_rx) begin
        case (r_state)
          S_RDID: begin
            if (r_idx == 8'd0)      r_dev_id[15:8] <= read_data;
            else if (r_idx == 8'd1) r_dev_id[7:0]  <= read_data;
          end
          S_POLL1, S_POLL2: r_wip <= read_data[WIP_BIT];
          S_READ: begin
            if ((read_data != (PAT_SEED + r_idx)) && (r_err_cnt != 9'd256))
              r_err_cnt <= r_err_cnt + 9'd1;
          end
          default: ;
        endcase
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
            r_timeout <= 1'b0;
            r_err_cnt <= 9'd0;
            r_dev_id  <= 16'h0000;
            r_busy    <= 1'b1;
            r_state   <= S_RDID;
          end
        end
        S_RDID:  if (w_cmd_done) r_state <= S_WREN1;
        S_WREN1: if (w_cmd_done) r_state <= S_SE;
        S_SE: begin
          if (w_cmd_done) begin
            r_poll_cnt <= 20'd0;
            r_state    <= S_POLL1;
          end
        end
        S_WREN2: if (w_cmd_done) r_state <= S_PP;
        S_PP: begin
          if (w_cmd_done) begin
            r_poll_cnt <= 20'd0;
            r_state    <= S_POLL2;
          end
        end
        S_POLL1, S_POLL2: begin
          if (w_cmd_done) begin
            if (!w_wip) begin
              r_state <= (r_state == S_POLL1) ? S_WREN2 : S_READ;
            end else begin
              r_poll_cnt <= r_poll_cnt + 20'd1;
              if (({1'b0, r_poll_cnt} + 21'd1) >= {1'b0, POLL_MAX}) begin
                r_state <= S_TOUT;
              end else begin
                r_ret     <= r_state;
                r_gap_cnt <= 16'd0;
                r_state   <= S_GAP;
              end
            end
          end
        end
        S_GAP: begin
          if (({1'b0, r_gap_cnt} + 17'd1) >= {1'b0, POLL_GAP}) r_state <= r_ret;
          else r_gap_cnt <= r_gap_cnt + 16'd1;
        end
        S_READ:  if (w_cmd_done) r_state <= S_DONE;
        S_DONE: begin
          r_busy  <= 1'b0;
          r_pass  <= (r_err_cnt == 9'd0);
          r_fail  <= (r_err_cnt != 9'd0);
          r_state <= S_IDLE;
        end
        S_TOUT: begin
          r_timeout <= 1'b1;
          r_fail    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qspi_flash_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_qspi_flash_seq
// Brief   : Self-checking bench with a behavioural QSPI driver/flash model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_qspi_flash_seq;

  localparam logic [23:0] FA   = 24'h012300;
  localparam int          GAP  = 10;
  localparam int          PMAX = 6;
  localparam logic [7:0]  SEED = 8'h00;
  localparam int          BUDGET = 5000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        done_sig = 1'b0;
  logic        read_byte_valid = 1'b0;
  logic [7:0]  read_data = 8'h00;
  logic [4:0]  cmd_type;
  logic [7:0]  cmd_code;
  logic [23:0] qspi_addr;
  logic        busy, pass, fail, timeout;
  logic [15:0] dev_id;
  logic [8:0]  err_cnt;
  logic [3:0]  seq_state;

  always #20 clk = ~clk;

  qspi_flash_seq #(
    .FLASH_ADDR (FA),
    .POLL_GAP   (16'd10),
    .POLL_MAX   (20'd6),
    .PAT_SEED   (SEED)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .cmd_type        (cmd_type),
    .cmd_code        (cmd_code),
    .qspi_addr       (qspi_addr),
    .done_sig        (done_sig),
    .read_data       (read_data),
    .read_byte_valid (read_byte_valid),
    .busy            (busy),
    .pass            (pass),
    .fail            (fail),
    .timeout         (timeout),
    .dev_id          (dev_id),
    .err_cnt         (err_cnt),
    .seq_state       (seq_state)
  );

  // ---------------- model configuration (written by the main process) ----
  logic [7:0] m_id0 = 8'hEF, m_id1 = 8'h16;
  int         m_busy1 = 0, m_busy2 = 0;
  bit         m_stuck = 0, m_all_bad = 0, m_spurious = 0;
  int         m_cidx0 = -1, m_cidx1 = -1;
  logic [7:0] m_cval0 = 8'h00, m_cval1 = 8'h00;

  int m_phase = 1;
  int m_phase_rdsr = 0;

  function automatic logic [7:0] rd_byte(input int i);
    logic [7:0] b;
    b = SEED + 8'(i);
    if (m_all_bad) b = b ^ 8'hFF;
    if (i == m_cidx0) b = m_cval0;
    if (i == m_cidx1) b = m_cval1;
    return b;
  endfunction

  function automatic logic [7:0] exp_code(input logic [3:0] t);
    case (t)
      4'h0: return 8'h90;
      4'h1: return 8'h06;
      4'h2: return 8'h20;
      4'h3: return 8'h05;
      4'h5: return 8'h02;
      4'h7: return 8'h03;
      default: return 8'hXX;
    endcase
  endfunction

  function automatic logic [23:0] exp_addr(input logic [3:0] t);
    return (t == 4'h2 || t == 4'h5 || t == 4'h7) ? FA : 24'h000000;
  endfunction

  // Serve one request: short latency, data bytes, then done
  task automatic serve();
    logic [3:0] t;
    int         nb;
    int         bsy;
    logic [7:0] st;
    t  = cmd_type[3:0];
    nb = 0;
    st = 8'h00;
    case (t)
      4'h0: nb = 2;
      4'h2: begin m_phase = 1; m_phase_rdsr = 0; end
      4'h5: begin m_phase = 2; m_phase_rdsr = 0; end
      4'h3: begin
        nb  = 1;
        bsy = (m_phase == 2) ? m_busy2 : m_busy1;
        st  = m_stuck ? 8'h03 : ((m_phase_rdsr < bsy) ? 8'h01 : 8'h00);
        m_phase_rdsr++;
      end
      4'h7: nb = 256;
      default: nb = 0;
    endcase
    repeat (2) begin
      @(posedge clk); #1;
      if (rst) return;
    end
    for (int i = 0; i < nb; i++) begin
      read_byte_valid = 1'b1;
      if (t == 4'h0)      read_data = (i == 0) ? m_id0 : m_id1;
      else if (t == 4'h3) read_data = st;
      else                read_data = rd_byte(i);
      // last READ byte arrives together with done
      if (t == 4'h7 && i == nb - 1) done_sig = 1'b1;
      @(posedge clk); #1;
      read_byte_valid = 1'b0;
      read_data = 8'h00;
      if (rst) begin done_sig = 1'b0; return; end
    end
    if (t != 4'h7) begin
      done_sig = 1'b1;
      @(posedge clk); #1;
    end
    done_sig = 1'b0;
    if (m_spurious) begin
      done_sig = 1'b1;
      read_byte_valid = 1'b1;
      read_data = 8'hAA;
      @(posedge clk); #1;
      done_sig = 1'b0;
      read_byte_valid = 1'b0;
      read_data = 8'h00;
    end
  endtask

  initial begin : drv_model
    forever begin
      @(posedge clk); #1;
      if (cmd_type[4] && !rst) serve();
    end
  end

  // ---------------- bus monitor ----------------
  int         tot_rdsr = 0, tot_pp = 0;
  int         viol_gap2 = 0, viol_pollgap = 0, viol_hold = 0, viol_field = 0;
  logic [3:0] seq_log[$];
  logic       prev_req = 1'b0;
  logic [36:0] prev_bus = '0;
  logic [3:0] last_t = 4'hF;
  int         low_run = 100;

  always @(negedge clk) begin
    if (cmd_type[4]) begin
      if (!prev_req) begin
        seq_log.push_back(cmd_type[3:0]);
        if (cmd_type[3:0] == 4'h3) tot_rdsr++;
        if (cmd_type[3:0] == 4'h5) tot_pp++;
        if (low_run < 2) viol_gap2++;
        if (cmd_type[3:0] == 4'h3 && last_t == 4'h3 && low_run < GAP) viol_pollgap++;
        if (cmd_code !== exp_code(cmd_type[3:0]) || qspi_addr !== exp_addr(cmd_type[3:0]))
          viol_field++;
        last_t = cmd_type[3:0];
      end else if ({cmd_type, cmd_code, qspi_addr} !== prev_bus) begin
        viol_hold++;
      end
      low_run = 0;
    end else begin
      low_run++;
    end
    prev_req = cmd_type[4];
    prev_bus = {cmd_type, cmd_code, qspi_addr};
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  id0, id1;
    int          busy1, busy2;
    bit          stuck, all_bad;
    int          cidx0, cidx1;
    logic [7:0]  cval0, cval1;
    logic [15:0] exp_id;
    bit          exp_pass, exp_fail, exp_tout;
    logic [8:0]  exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic load_cfg(input vec_t v);
    m_id0 = v.id0;  m_id1 = v.id1;
    m_busy1 = v.busy1; m_busy2 = v.busy2;
    m_stuck = v.stuck; m_all_bad = v.all_bad;
    m_cidx0 = v.cidx0; m_cidx1 = v.cidx1;
    m_cval0 = v.cval0; m_cval1 = v.cval1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int vi, input bit poke);
    int         s_rdsr, s_pp, s_seq, s_g2, s_pg, s_h, s_f;
    int         cyc;
    bit         ok;
    logic [3:0] exp_q[$];
    load_cfg(v);
    s_rdsr = tot_rdsr; s_pp = tot_pp; s_seq = seq_log.size();
    s_g2 = viol_gap2; s_pg = viol_pollgap; s_h = viol_hold; s_f = viol_field;
    pulse_start();
    check($sformatf("v%0d busy_after_start", vi), 32'(busy), 32'd1);
    cyc = 0;
    while (!(pass || fail) && cyc < BUDGET) begin
      @(posedge clk); #1;
      cyc++;
      if (poke && busy && (cyc % 97 == 0)) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc++;
      end
    end
    check($sformatf("v%0d finished_in_budget", vi), 32'(cyc < BUDGET), 32'd1);
    check($sformatf("v%0d busy_end", vi), 32'(busy), 32'd0);
    check($sformatf("v%0d state_idle", vi), 32'(seq_state), 32'd0);
    check($sformatf("v%0d dev_id", vi), 32'(dev_id), 32'(v.exp_id));
    check($sformatf("v%0d pass", vi), 32'(pass), 32'(v.exp_pass));
    check($sformatf("v%0d fail", vi), 32'(fail), 32'(v.exp_fail));
    check($sformatf("v%0d timeout", vi), 32'(timeout), 32'(v.exp_tout));
    check($sformatf("v%0d err_cnt", vi), 32'(err_cnt), 32'(v.exp_err));
    check($sformatf("v%0d rdsr_count", vi), 32'(tot_rdsr - s_rdsr),
          v.stuck ? 32'(PMAX) : 32'(v.busy1 + v.busy2 + 2));
    check($sformatf("v%0d pp_count", vi), 32'(tot_pp - s_pp), v.stuck ? 32'd0 : 32'd1);
    exp_q = {4'h0, 4'h1, 4'h2};
    if (v.stuck) begin
      for (int i = 0; i < PMAX; i++) exp_q.push_back(4'h3);
    end else begin
      for (int i = 0; i <= v.busy1; i++) exp_q.push_back(4'h3);
      exp_q.push_back(4'h1);
      exp_q.push_back(4'h5);
      for (int i = 0; i <= v.busy2; i++) exp_q.push_back(4'h3);
      exp_q.push_back(4'h7);
    end
    ok = ((seq_log.size() - s_seq) == exp_q.size());
    if (ok) begin
      for (int i = 0; i < exp_q.size(); i++)
        if (seq_log[s_seq + i] !== exp_q[i]) ok = 1'b0;
    end
    check($sformatf("v%0d request_order", vi), 32'(ok), 32'd1);
    check($sformatf("v%0d req_gap_violations", vi), 32'(viol_gap2 - s_g2), 32'd0);
    check($sformatf("v%0d poll_gap_violations", vi), 32'(viol_pollgap - s_pg), 32'd0);
    check($sformatf("v%0d hold_violations", vi), 32'(viol_hold - s_h), 32'd0);
    check($sformatf("v%0d code_addr_violations", vi), 32'(viol_field - s_f), 32'd0);
  endtask

  initial begin : watchdog
    #2400000;
    $display("FAIL watchdog: simulation did not complete, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cyc;
    vec_t nom;
    //          id0    id1    b1 b2 stk bad cidx0 cidx1 cval0  cval1  exp_id      pass fail tout err
    vecs[0] = '{8'hEF, 8'h16, 0, 0, 0, 0,  -1,   -1,  8'h00, 8'h00, 16'hEF16, 1, 0, 0, 9'd0};
    vecs[1] = '{8'hEF, 8'h16, 0, 0, 0, 0,  'h37, -1,  8'h00, 8'h00, 16'hEF16, 0, 1, 0, 9'd1};
    vecs[2] = '{8'hEF, 8'h16, 5, 0, 0, 0,  -1,   -1,  8'h00, 8'h00, 16'hEF16, 1, 0, 0, 9'd0};
    vecs[3] = '{8'hEF, 8'h16, 0, 0, 1, 0,  -1,   -1,  8'h00, 8'h00, 16'hEF16, 0, 1, 1, 9'd0};
    vecs[4] = '{8'hC2, 8'h20, 0, 2, 0, 0,  0,    255, 8'h80, 8'h00, 16'hC220, 0, 1, 0, 9'd2};
    vecs[5] = '{8'h9D, 8'h17, 0, 0, 0, 1,  -1,   -1,  8'h00, 8'h00, 16'h9D17, 0, 1, 0, 9'd256};
    nom = vecs[0];

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset cmd_type", 32'(cmd_type), 32'd0);
    check("reset outputs", 32'({busy, pass, fail, timeout}), 32'd0);
    check("reset dev_id", 32'(dev_id), 32'd0);
    check("reset err_cnt", 32'(err_cnt), 32'd0);
    check("reset seq_state", 32'(seq_state), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i, 1'b0);

    // Reset while the page program request is outstanding
    load_cfg(nom);
    pulse_start();
    cyc = 0;
    while (!(seq_state == 4'h6 && cmd_type[4]) && cyc < BUDGET) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rst_pp reached_pp", 32'(cyc < BUDGET), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_pp request", 32'(cmd_type), 32'd0);
    check("rst_pp flags", 32'({busy, pass, fail, timeout}), 32'd0);
    check("rst_pp dev_id", 32'(dev_id), 32'd0);
    check("rst_pp state", 32'(seq_state), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    run_vec(nom, 6, 1'b0);

    // Start pulses while busy, plus done/valid pulses with request low
    m_spurious = 1'b1;
    nom.busy1 = 1;
    run_vec(nom, 7, 1'b1);
    m_spurious = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
